// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares one quad-SPI flash read engine between video (V) and aux (A).
// Default is V priority with an A starvation guard; define FLASH_ARB_RR_EN for round-robin.
module flash_read_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 12,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [LEN_W-1:0]  v_len,
    output logic              v_gnt,
    output logic              v_dvalid,
    output logic              v_done,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [LEN_W-1:0]  a_len,
    output logic              a_gnt,
    output logic              a_dvalid,
    output logic              a_done,
    output logic [7:0]        dout,
    output logic              f_start,
    output logic [ADDR_W-1:0] f_addr,
    output logic [LEN_W-1:0]  f_len,
    input  logic              f_dvalid,
    input  logic [7:0]        f_data,
    input  logic              f_done,
    output logic              owner,
    output logic              busy,
    output logic              len_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        dout_q, dout_d;
    logic              v_gnt_q, v_gnt_d, a_gnt_q, a_gnt_d;
    logic              v_dv_q, v_dv_d, a_dv_q, a_dv_d;
    logic              v_done_q, v_done_d, a_done_q, a_done_d;
    logic              f_start_q, f_start_d;
    logic              busy_q, busy_d;
    logic              len_err_q, len_err_d;
    logic              win_a;

`ifdef FLASH_ARB_RR_EN
    // Remembers who was granted last; reset value lets V win the first tie.
    logic last_a_q, last_a_d;
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    logic [SW-1:0] starve_q, starve_d;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        v_gnt_d   = 1'b0;
        a_gnt_d   = 1'b0;
        v_dv_d    = 1'b0;
        a_dv_d    = 1'b0;
        v_done_d  = 1'b0;
        a_done_d  = 1'b0;
        f_start_d = 1'b0;
        len_err_d = 1'b0;
`ifdef FLASH_ARB_RR_EN
        last_a_d  = last_a_q;
        win_a     = a_req && (!v_req || !last_a_q);
`else
        starve_d  = starve_q;
        win_a     = a_req && (!v_req || starve_q == SMAX);
`endif

        unique case (state_q)
            IDLE: begin
                if (v_req || a_req) begin
                    owner_d = win_a;
                    addr_d  = win_a ? a_addr : v_addr;
                    len_d   = win_a ? a_len : v_len;
                    cnt_d   = '0;
                    v_gnt_d = !win_a;
                    a_gnt_d = win_a;
                    state_d = ISSUE;
`ifdef FLASH_ARB_RR_EN
                    last_a_d = win_a;
`else
                    if (win_a)
                        starve_d = '0;
                    else if (a_req && starve_q != SMAX)
                        starve_d = starve_q + 1'b1;
`endif
                end
            end
            ISSUE: begin
                if (len_q == '0) begin
                    v_done_d = !owner_q;
                    a_done_d = owner_q;
                    state_d  = IDLE;
                end else begin
                    f_start_d = 1'b1;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (f_dvalid) begin
                    if (cnt_q < len_q) begin
                        dout_d = f_data;
                        v_dv_d = !owner_q;
                        a_dv_d = owner_q;
                    end
                    // Keeps counting past len so overruns still flag len_err.
                    if (cnt_q != '1)
                        cnt_d = cnt_q + 1'b1;
                end
                if (f_done) begin
                    v_done_d  = !owner_q;
                    a_done_d  = owner_q;
                    len_err_d = (cnt_d != len_q);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            v_gnt_q   <= 1'b0;
            a_gnt_q   <= 1'b0;
            v_dv_q    <= 1'b0;
            a_dv_q    <= 1'b0;
            v_done_q  <= 1'b0;
            a_done_q  <= 1'b0;
            f_start_q <= 1'b0;
            busy_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            v_gnt_q   <= v_gnt_d;
            a_gnt_q   <= a_gnt_d;
            v_dv_q    <= v_dv_d;
            a_dv_q    <= a_dv_d;
            v_done_q  <= v_done_d;
            a_done_q  <= a_done_d;
            f_start_q <= f_start_d;
            busy_q    <= busy_d;
            len_err_q <= len_err_d;
        end
    end

`ifdef FLASH_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_a_q <= 1'b1;
        else     last_a_q <= last_a_d;
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`endif

    assign v_gnt    = v_gnt_q;
    assign a_gnt    = a_gnt_q;
    assign v_dvalid = v_dv_q;
    assign a_dvalid = a_dv_q;
    assign v_done   = v_done_q;
    assign a_done   = a_done_q;
    assign dout     = dout_q;
    assign f_start  = f_start_q;
    assign f_addr   = addr_q;
    assign f_len    = len_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: vector table, reset/arbitration sequences and a randomized
// run against a transaction-level reference model of flash_read_arbiter.
module tb_flash_read_arbiter;
    localparam int AW = 24;
    localparam int LW = 12;
    localparam int SM = 8;
    localparam int CNT_MAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          v_req, a_req;
    logic [AW-1:0] v_addr, a_addr;
    logic [LW-1:0] v_len, a_len;
    logic          v_gnt, v_dvalid, v_done;
    logic          a_gnt, a_dvalid, a_done;
    logic [7:0]    dout;
    logic          f_start;
    logic [AW-1:0] f_addr;
    logic [LW-1:0] f_len;
    logic          f_dvalid;
    logic [7:0]    f_data;
    logic          f_done;
    logic          owner, busy, len_err;

    int checks = 0;
    int errors = 0;

    flash_read_arbiter #(.ADDR_W(AW), .LEN_W(LW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .v_req(v_req), .v_addr(v_addr), .v_len(v_len),
        .v_gnt(v_gnt), .v_dvalid(v_dvalid), .v_done(v_done),
        .a_req(a_req), .a_addr(a_addr), .a_len(a_len),
        .a_gnt(a_gnt), .a_dvalid(a_dvalid), .a_done(a_done),
        .dout(dout), .f_start(f_start), .f_addr(f_addr), .f_len(f_len),
        .f_dvalid(f_dvalid), .f_data(f_data), .f_done(f_done),
        .owner(owner), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Flag order: {v_gnt,a_gnt,v_dvalid,a_dvalid,v_done,a_done,f_start,busy,len_err,owner}
    function automatic logic [9:0] flags();
        return {v_gnt, a_gnt, v_dvalid, a_dvalid, v_done, a_done,
                f_start, busy, len_err, owner};
    endfunction

    task automatic check(string name, logic [9:0] ef, logic [7:0] ed,
                         logic [AW-1:0] ea, logic [LW-1:0] el);
        checks++;
        if (flags() !== ef || dout !== ed || f_addr !== ea || f_len !== el) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s t=%0t got flags=%b dout=%h addr=%h len=%0d want flags=%b dout=%h addr=%h len=%0d",
                         name, $time, flags(), dout, f_addr, f_len, ef, ed, ea, el);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          vr, ar;
        logic [LW-1:0] vl, al;
        logic          fv;
        logic [7:0]    fd;
        logic          fdn;
        logic [9:0]    ef;
        logic [7:0]    ed;
        logic [AW-1:0] ea;
        logic [LW-1:0] el;
    } vec_t;

    vec_t tbl[$];

    task automatic row(logic vr, logic ar, int vl, int al, logic fv, logic [7:0] fd,
                       logic fdn, logic [9:0] ef, logic [7:0] ed, logic [AW-1:0] ea, int el);
        vec_t r;
        r.vr = vr; r.ar = ar; r.vl = LW'(vl); r.al = LW'(al);
        r.fv = fv; r.fd = fd; r.fdn = fdn;
        r.ef = ef; r.ed = ed; r.ea = ea; r.el = LW'(el);
        tbl.push_back(r);
    endtask

    // Reference model state: one open transaction at a time.
    bit            m_open, m_run, m_own, m_last_a, m_gv, m_ga;
    logic [AW-1:0] m_addr;
    int            m_len, m_sent, m_starve;
    logic [7:0]    m_dout;
    bit            e_on;
    int            e_left;

    task automatic do_reset();
        rst = 1'b1;
        v_req = 0; a_req = 0; v_addr = '0; a_addr = '0; v_len = '0; a_len = '0;
        f_dvalid = 0; f_data = '0; f_done = 0;
        m_open = 0; m_run = 0; m_own = 0; m_last_a = 1; m_addr = '0;
        m_len = 0; m_sent = 0; m_starve = 0; m_dout = '0; e_on = 0; e_left = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic step();
        bit win_a, dv, dn, fst, lerr;
        logic [9:0] ef;
        dv = 0; dn = 0; fst = 0; lerr = 0; m_gv = 0; m_ga = 0;
        if (!m_open) begin
            if (v_req || a_req) begin
`ifdef FLASH_ARB_RR_EN
                win_a = a_req && (!v_req || !m_last_a);
                m_last_a = win_a;
`else
                win_a = a_req && (!v_req || m_starve == SM);
                if (win_a) m_starve = 0;
                else if (a_req && m_starve < SM) m_starve++;
`endif
                m_own = win_a;
                m_addr = win_a ? a_addr : v_addr;
                m_len = win_a ? int'(a_len) : int'(v_len);
                m_sent = 0; m_open = 1; m_run = 0;
                m_gv = !win_a; m_ga = win_a;
            end
        end else if (!m_run) begin
            if (m_len == 0) begin dn = 1; m_open = 0; end
            else begin fst = 1; m_run = 1; end
        end else begin
            if (f_dvalid) begin
                if (m_sent < m_len) begin dv = 1; m_dout = f_data; end
                if (m_sent < CNT_MAX) m_sent++;
            end
            if (f_done) begin
                dn = 1; lerr = (m_sent != m_len); m_open = 0; m_run = 0;
            end
        end
        ef = {m_gv, m_ga, dv & !m_own, dv & m_own, dn & !m_own, dn & m_own,
              fst, m_open, lerr, m_own};
        tick();
        check("cycle", ef, m_dout, m_addr, LW'(m_len));
    endtask

    // Flash engine stand-in: returns len-1..len+2 bytes with gaps, strays while idle.
    task automatic engine();
        f_dvalid = 0; f_done = 0;
        if (e_on) begin
            if (e_left > 0 && $urandom_range(3) != 0) begin
                f_dvalid = 1; f_data = 8'($urandom); e_left--;
                if (e_left == 0 && $urandom_range(1) == 1) begin f_done = 1; e_on = 0; end
            end else if (e_left == 0) begin
                f_done = 1; e_on = 0;
            end
        end else if (f_start) begin
            e_on = 1;
            e_left = int'(f_len) + int'($urandom_range(3)) - 1;
            if (e_left < 0) e_left = 0;
        end else if (!m_run && $urandom_range(7) == 0) begin
            f_dvalid = $urandom_range(1) == 1;
            f_data = 8'($urandom);
            f_done = !f_dvalid;
        end
    endtask

    task automatic requesters();
        if (m_gv) begin
            if ($urandom_range(1) == 1) v_req = 0;
            else begin v_addr = AW'($urandom); v_len = LW'($urandom_range(6)); end
        end else if (!v_req && $urandom_range(3) == 0) begin
            v_req = 1; v_addr = AW'($urandom); v_len = LW'($urandom_range(6));
        end else if (v_req && $urandom_range(31) == 0) v_req = 0;
        if (m_ga) begin
            if ($urandom_range(1) == 1) a_req = 0;
            else begin a_addr = AW'($urandom); a_len = LW'($urandom_range(6)); end
        end else if (!a_req && $urandom_range(3) == 0) begin
            a_req = 1; a_addr = AW'($urandom); a_len = LW'($urandom_range(6));
        end else if (a_req && $urandom_range(31) == 0) a_req = 0;
    endtask

    initial begin
        bit got[$];
        bit exp_a;
        logic [AW-1:0] A1, A2;
        A1 = 24'h010000;
        A2 = 24'h020000;

        do_reset();
        check("reset", 10'b0, 8'h00, '0, '0);

        row(1,0,4,0,0,8'h00,0, 10'b1000000100, 8'h00, A1, 4);
        row(0,0,4,0,0,8'h00,0, 10'b0000001100, 8'h00, A1, 4);
        row(0,0,4,0,1,8'hAA,0, 10'b0010000100, 8'hAA, A1, 4);
        row(0,0,4,0,1,8'hBB,0, 10'b0010000100, 8'hBB, A1, 4);
        row(0,0,4,0,1,8'hCC,0, 10'b0010000100, 8'hCC, A1, 4);
        row(0,0,4,0,1,8'hDD,0, 10'b0010000100, 8'hDD, A1, 4);
        row(0,0,4,0,0,8'h00,1, 10'b0000100000, 8'hDD, A1, 4);
        row(0,0,4,0,0,8'h00,1, 10'b0000000000, 8'hDD, A1, 4);
        row(0,1,4,0,0,8'h00,0, 10'b0100000101, 8'hDD, A2, 0);
        row(0,0,4,0,0,8'h00,0, 10'b0000010001, 8'hDD, A2, 0);
        row(0,0,4,0,1,8'h55,0, 10'b0000000001, 8'hDD, A2, 0);
        row(0,1,4,2,0,8'h00,0, 10'b0100000101, 8'hDD, A2, 2);
        row(0,0,4,2,1,8'h77,0, 10'b0000001101, 8'hDD, A2, 2);
        row(0,0,4,2,1,8'h11,0, 10'b0001000101, 8'h11, A2, 2);
        row(0,0,4,2,1,8'h22,1, 10'b0001010001, 8'h22, A2, 2);
        row(0,1,4,3,0,8'h00,0, 10'b0100000101, 8'h22, A2, 3);
        row(0,0,4,3,0,8'h00,0, 10'b0000001101, 8'h22, A2, 3);
        row(0,0,4,3,1,8'h01,0, 10'b0001000101, 8'h01, A2, 3);
        row(0,0,4,3,1,8'h02,0, 10'b0001000101, 8'h02, A2, 3);
        row(0,0,4,3,1,8'h03,0, 10'b0001000101, 8'h03, A2, 3);
        row(0,0,4,3,1,8'h04,0, 10'b0000000101, 8'h03, A2, 3);
        row(0,0,4,3,1,8'h05,0, 10'b0000000101, 8'h03, A2, 3);
        row(0,0,4,3,0,8'h00,1, 10'b0000010011, 8'h03, A2, 3);

        v_addr = A1;
        a_addr = A2;
        foreach (tbl[i]) begin
            v_req = tbl[i].vr; a_req = tbl[i].ar;
            v_len = tbl[i].vl; a_len = tbl[i].al;
            f_dvalid = tbl[i].fv; f_data = tbl[i].fd; f_done = tbl[i].fdn;
            tick();
            check($sformatf("row%0d", i), tbl[i].ef, tbl[i].ed, tbl[i].ea, tbl[i].el);
        end

        // Reset in the middle of a transfer, then re-grant of a pending request.
        do_reset();
        v_req = 1; v_addr = 24'h030000; v_len = 8;
        tick();
        v_req = 0;
        tick();
        f_dvalid = 1; f_data = 8'h5A;
        tick();
        f_data = 8'h5B;
        tick();
        check("t5_pre", 10'b0010000100, 8'h5B, 24'h030000, 8);
        f_dvalid = 0;
        v_req = 1; v_addr = 24'h040000; v_len = 2;
        #2 rst = 1'b1;
        #1 check("t5_async", 10'b0, 8'h00, '0, '0);
        tick();
        check("t5_hold", 10'b0, 8'h00, '0, '0);
        rst = 1'b0;
        tick();
        check("t5_regrant", 10'b1000000100, 8'h00, 24'h040000, 2);

        // Both requesters held high: grant order.
        do_reset();
        v_req = 1; a_req = 1; v_addr = 24'h000100; a_addr = 24'h000200;
        v_len = 1; a_len = 1;
        for (int c = 0; c < 400 && got.size() < 18; c++) begin
            step();
            if (v_gnt) got.push_back(1'b0);
            if (a_gnt) got.push_back(1'b1);
            engine();
        end
        if (got.size() < 18) begin
            checks++; errors++;
            $display("FAIL order_timeout got %0d grants want 18", got.size());
        end
        foreach (got[i]) begin
            if (i < 18) begin
`ifdef FLASH_ARB_RR_EN
                exp_a = (i % 2) == 1;
`else
                exp_a = (i == 8) || (i == 17);
`endif
                checks++;
                if (got[i] !== exp_a) begin
                    errors++;
                    $display("FAIL order[%0d] got owner %0d want %0d", i, got[i], exp_a);
                end
            end
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            engine();
            requesters();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
